m_seq_divider: RTL and testbench

//  Multi-cycle restoring divider. It is the inverse companion of the ALU multiplier (SELECT 3'b100).
//  It produces one quotient bit per clock and sits beside the ALU on the same DATA1/DATA2 operand buses.

---
 rtl/div_pkg.sv | 20 ++
 rtl/m_div_step.sv | 31 +++
 rtl/m_seq_divider.sv | 161 ++++++++++++++++
 tb/tb_m_seq_divider.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state
// encoding and the iteration-counter width.
package div_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } div_state_e;

    localparam int DIV_WIDTH_DEF = 8;
    localparam int DIV_CNT_W     = $clog2(DIV_WIDTH_DEF + 1);

    // Counter width able to hold 0..width
    function automatic int div_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/m_div_step.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder, trial-subtract the divisor and keep the
// difference only when it is non-negative.
module m_div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    localparam int RW = WIDTH + 1;

    logic [WIDTH+1:0] shifted_s;
    logic [WIDTH+1:0] divisor_ext_s;

    // Trial subtraction; a quotient bit of 1 means the subtraction is kept
    always_comb begin
        shifted_s     = {rem_in, bit_in};
        divisor_ext_s = {2'b00, divisor};
        q_bit         = (shifted_s >= divisor_ext_s);
        if (q_bit) begin
            rem_out = RW'(shifted_s - divisor_ext_s);
        end else begin
            rem_out = RW'(shifted_s);
        end
    end

endmodule

// File: rtl/m_seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, MSB first.
// Sequence IDLE -> CALC (WIDTH cycles) -> FIXUP -> DONE; a zero divisor
// jumps straight to DONE. Define DIV_SIGNED_EN to honour signed_op
// (magnitudes divided, signs applied in FIXUP); otherwise every operation
// is unsigned and signed_op is ignored, with identical latency.
module m_seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             signed_op,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int               CW       = div_cnt_width(WIDTH);
    localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};

    div_state_e       state_r, next_state_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] dvd_r;        // dividend shift register, fills with quotient bits
    logic [WIDTH-1:0] dvs_r;        // divisor magnitude
    logic [WIDTH:0]   rem_r;        // partial remainder
    logic             neg_q_r, neg_r_r;
    logic [WIDTH-1:0] quotient_r, remainder_r;
    logic             busy_r, done_r, dbz_r;

    logic             accept_s, div_zero_s;
    logic [WIDTH-1:0] dvd_mag_s, dvs_mag_s;
    logic             neg_q_s, neg_r_s;
    logic [WIDTH:0]   step_rem_s;
    logic             step_q_s;

    assign accept_s   = start && ((state_r == S_IDLE) || (state_r == S_DONE));
    assign div_zero_s = (divisor == ZERO_W);

`ifdef DIV_SIGNED_EN
    logic dvd_neg_s, dvs_neg_s;

    // Operand magnitudes and result sign flags for two's-complement divides
    always_comb begin
        dvd_neg_s = signed_op & dividend[WIDTH-1];
        dvs_neg_s = signed_op & divisor[WIDTH-1];
        dvd_mag_s = dvd_neg_s ? (ZERO_W - dividend) : dividend;
        dvs_mag_s = dvs_neg_s ? (ZERO_W - divisor) : divisor;
        neg_q_s   = dvd_neg_s ^ dvs_neg_s;
        neg_r_s   = dvd_neg_s;
    end
`else
    logic unused_signed_op_s;

    // Unsigned-only build: operands pass straight through, no sign fixup
    always_comb begin
        unused_signed_op_s = signed_op;
        dvd_mag_s          = dividend;
        dvs_mag_s          = divisor;
        neg_q_s            = 1'b0;
        neg_r_s            = 1'b0;
    end
`endif

    m_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_r),
        .bit_in  (dvd_r[WIDTH-1]),
        .divisor (dvs_r),
        .rem_out (step_rem_s),
        .q_bit   (step_q_s)
    );

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (start) begin
                    next_state_s = div_zero_s ? S_DONE : S_CALC;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_CALC: begin
                if (cnt_r == LAST_CNT) begin
                    next_state_s = S_FIXUP;
                end else begin
                    next_state_s = S_CALC;
                end
            end
            S_FIXUP: next_state_s = S_DONE;
            default: next_state_s = S_IDLE;
        endcase
    end

    // State register with registered busy/done decodes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s == S_CALC) || (next_state_s == S_FIXUP);
            done_r  <= (next_state_s == S_DONE);
        end
    end

    // Operand latch, iteration datapath and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r       <= {CW{1'b0}};
            dvd_r       <= ZERO_W;
            dvs_r       <= ZERO_W;
            rem_r       <= {(WIDTH+1){1'b0}};
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
            quotient_r  <= ZERO_W;
            remainder_r <= ZERO_W;
            dbz_r       <= 1'b0;
        end else if (accept_s) begin
            cnt_r   <= {CW{1'b0}};
            dvd_r   <= dvd_mag_s;
            dvs_r   <= dvs_mag_s;
            rem_r   <= {(WIDTH+1){1'b0}};
            neg_q_r <= neg_q_s;
            neg_r_r <= neg_r_s;
            dbz_r   <= div_zero_s;
            if (div_zero_s) begin
                quotient_r  <= ONES_W;
                remainder_r <= dividend;
            end else begin
                quotient_r  <= quotient_r;
                remainder_r <= remainder_r;
            end
        end else if (state_r == S_CALC) begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            rem_r <= step_rem_s;
            dvd_r <= {dvd_r[WIDTH-2:0], step_q_s};
        end else if (state_r == S_FIXUP) begin
            quotient_r  <= neg_q_r ? (ZERO_W - dvd_r) : dvd_r;
            remainder_r <= neg_r_r ? (ZERO_W - rem_r[WIDTH-1:0]) : rem_r[WIDTH-1:0];
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_m_seq_divider.sv
// Self-checking bench for m_seq_divider (WIDTH = 8) against a plain
// arithmetic reference model.
module tb_m_seq_divider;

    localparam int W   = 8;
    localparam int LAT = W + 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend, divisor;
    logic         signed_op;
    logic [W-1:0] quotient, remainder;
    logic         busy, done, div_by_zero;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    m_seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .signed_op   (signed_op),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    // Reference model: results straight from integer arithmetic
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic z, output int lat);
        int sa, sb;
        if (b == 0) begin
            q = '1; r = a; z = 1'b1; lat = 1;
        end else begin
            z = 1'b0; lat = LAT;
`ifdef DIV_SIGNED_EN
            if (s) begin
                sa = $signed(a); sb = $signed(b);
                q = W'(sa / sb); r = W'(sa % sb);
            end else begin
                q = a / b; r = a % b;
            end
`else
            if (s) begin q = a / b; r = a % b; end
            else   begin q = a / b; r = a % b; end
`endif
        end
    endfunction

    // Present operands with start for exactly one rising edge
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(negedge clk);
        dividend = a; divisor = b; signed_op = s; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dividend = W'($urandom); divisor = W'($urandom); signed_op = 1'($urandom);
    endtask

    // Launch and wait (bounded) for done; lat = cycle of done, 0 on timeout
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                           output logic [W-1:0] q, output logic [W-1:0] r,
                           output logic z, output int lat);
        launch(a, b, s);
        lat = 0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(negedge clk);
            if (done) lat = c;
        end
        q = quotient; r = remainder; z = div_by_zero;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0; signed_op = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({quotient, remainder, busy, done, div_by_zero} !== {(2*W+3){1'b0}}) begin
            n_fails++;
            $display("FAIL reset_outputs: got q=%0h r=%0h busy=%b done=%b dbz=%b expected all 0",
                     quotient, remainder, busy, done, div_by_zero);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_idle: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_unsigned_basic();
        logic [W-1:0] eq, er; logic ez; int el;
        ref_div(8'd100, 8'd7, 1'b0, eq, er, ez, el);
        launch(8'd100, 8'd7, 1'b0);
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== (c <= LAT - 1) || done !== (c == LAT)) begin
                n_fails++;
                $display("FAIL basic_timing cycle %0d: got busy=%b done=%b expected busy=%b done=%b",
                         c, busy, done, (c <= LAT - 1), (c == LAT));
            end
        end
        n_checks++;
        if (quotient !== eq || remainder !== er || div_by_zero !== ez) begin
            n_fails++;
            $display("FAIL basic_100_7: got q=%0d r=%0d dbz=%b expected q=%0d r=%0d dbz=%b",
                     quotient, remainder, div_by_zero, eq, er, ez);
        end
    endtask

    task automatic test_div_by_zero();
        logic [W-1:0] q, r; logic z; int lat;
        run_div(8'h2A, 8'h00, 1'b0, q, r, z, lat);
        n_checks++;
        if (q !== 8'hFF || r !== 8'h2A || z !== 1'b1 || lat != 1) begin
            n_fails++;
            $display("FAIL div_zero: got q=%0h r=%0h dbz=%b lat=%0d expected q=ff r=2a dbz=1 lat=1",
                     q, r, z, lat);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || div_by_zero !== 1'b1) begin
            n_fails++;
            $display("FAIL div_zero_hold: got done=%b dbz=%b expected done=0 dbz=1", done, div_by_zero);
        end
    endtask

    task automatic test_signed();
        logic [W-1:0] q, r; logic z; int lat;
`ifdef DIV_SIGNED_EN
        run_div(8'hF9, 8'h02, 1'b1, q, r, z, lat);
        n_checks++;
        if (q !== 8'hFD || r !== 8'hFF || z !== 1'b0 || lat != LAT) begin
            n_fails++;
            $display("FAIL signed_m7_2: got q=%0h r=%0h dbz=%b lat=%0d expected q=fd r=ff dbz=0 lat=%0d",
                     q, r, z, lat, LAT);
        end
        run_div(8'h80, 8'hFF, 1'b1, q, r, z, lat);
        n_checks++;
        if (q !== 8'h80 || r !== 8'h00 || z !== 1'b0 || lat != LAT) begin
            n_fails++;
            $display("FAIL signed_overflow: got q=%0h r=%0h dbz=%b lat=%0d expected q=80 r=0 dbz=0 lat=%0d",
                     q, r, z, lat, LAT);
        end
        run_div(8'h07, 8'hFE, 1'b1, q, r, z, lat);
        n_checks++;
        if (q !== 8'hFD || r !== 8'h01 || lat != LAT) begin
            n_fails++;
            $display("FAIL signed_7_m2: got q=%0h r=%0h lat=%0d expected q=fd r=01 lat=%0d", q, r, lat, LAT);
        end
`else
        run_div(8'hF9, 8'h02, 1'b1, q, r, z, lat);
        n_checks++;
        if (q !== 8'd124 || r !== 8'd1 || z !== 1'b0 || lat != LAT) begin
            n_fails++;
            $display("FAIL signed_ignored: got q=%0h r=%0h dbz=%b lat=%0d expected q=7c r=01 dbz=0 lat=%0d",
                     q, r, z, lat, LAT);
        end
`endif
    endtask

    task automatic test_start_while_busy();
        launch(8'd100, 8'd7, 1'b0);
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            if (c == 3) begin
                start = 1'b1; dividend = 8'd200; divisor = 8'd3; signed_op = 1'b0;
            end else begin
                start = 1'b0;
            end
            n_checks++;
            if (done !== (c == LAT)) begin
                n_fails++;
                $display("FAIL busy_start_done cycle %0d: got %b expected %b", c, done, (c == LAT));
            end
        end
        n_checks++;
        if (quotient !== 8'd14 || remainder !== 8'd2) begin
            n_fails++;
            $display("FAIL busy_start_result: got q=%0d r=%0d expected q=14 r=2", quotient, remainder);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] q, r; logic z; int lat;
        logic [W-1:0] eq, er; logic ez; int el;
        run_div(8'd200, 8'd9, 1'b0, q, r, z, lat);
        n_checks++;
        if (q !== 8'd22 || r !== 8'd2 || lat != LAT) begin
            n_fails++;
            $display("FAIL b2b_first: got q=%0d r=%0d lat=%0d expected q=22 r=2 lat=%0d", q, r, lat, LAT);
        end
        // Still inside the DONE cycle: launch the second division now
        ref_div(8'd77, 8'd5, 1'b0, eq, er, ez, el);
        dividend = 8'd77; divisor = 8'd5; signed_op = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            n_checks++;
            if (done !== (c == el) || busy !== (c < el)) begin
                n_fails++;
                $display("FAIL b2b_timing cycle %0d: got busy=%b done=%b expected busy=%b done=%b",
                         c, busy, done, (c < el), (c == el));
            end
        end
        n_checks++;
        if (quotient !== eq || remainder !== er || div_by_zero !== ez) begin
            n_fails++;
            $display("FAIL b2b_second: got q=%0d r=%0d dbz=%b expected q=%0d r=%0d dbz=%b",
                     quotient, remainder, div_by_zero, eq, er, ez);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] q, r; logic z; int lat; int seen;
        launch(8'd123, 8'd4, 1'b0);
        repeat (5) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({quotient, remainder, busy, done, div_by_zero} !== {(2*W+3){1'b0}}) begin
            n_fails++;
            $display("FAIL reset_async: got q=%0h r=%0h busy=%b done=%b dbz=%b expected all 0",
                     quotient, remainder, busy, done, div_by_zero);
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fails++;
            $display("FAIL reset_abort: got %0d busy/done cycles expected 0", seen);
        end
        run_div(8'd255, 8'd16, 1'b0, q, r, z, lat);
        n_checks++;
        if (q !== 8'd15 || r !== 8'd15 || z !== 1'b0 || lat != LAT) begin
            n_fails++;
            $display("FAIL after_reset_255_16: got q=%0d r=%0d dbz=%b lat=%0d expected q=15 r=15 dbz=0 lat=%0d",
                     q, r, z, lat, LAT);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, q, r, eq, er; logic s, z, ez; int lat, el;
        for (int i = 0; i < 320; i++) begin
            case (i)
                0:       begin a = 8'd0;   b = 8'd1;   end
                1:       begin a = 8'd255; b = 8'd255; end
                2:       begin a = 8'd255; b = 8'd1;   end
                3:       begin a = 8'd1;   b = 8'd255; end
                4:       begin a = 8'd128; b = 8'd255; end
                default: begin
                    a = W'($urandom);
                    b = (i % 17 == 0) ? 8'd0 : W'($urandom);
                end
            endcase
            s = 1'($urandom);
            ref_div(a, b, s, eq, er, ez, el);
            run_div(a, b, s, q, r, z, lat);
            n_checks++;
            if (q !== eq || r !== er || z !== ez || lat != el) begin
                n_fails++;
                $display("FAIL random a=%0h b=%0h s=%b: got q=%0h r=%0h dbz=%b lat=%0d expected q=%0h r=%0h dbz=%b lat=%0d",
                         a, b, s, q, r, z, lat, eq, er, ez, el);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_basic();
        test_div_by_zero();
        test_signed();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
